// File: rtl/lsu_pkg.sv
// lsu_pkg: memory-op size codes, LSU state encoding and the misalignment rule
// shared by the load/store unit and its lane aligner.
package lsu_pkg;
   localparam int MEM_SIZE_BITS = 2;
   localparam logic [MEM_SIZE_BITS-1:0] MEM_B = 2'd0;
   localparam logic [MEM_SIZE_BITS-1:0] MEM_H = 2'd1;
   localparam logic [MEM_SIZE_BITS-1:0] MEM_W = 2'd2;

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_RESP, S_ERR} lsu_state_e;

   // Size code 3 has no legal encoding, so it is reported as misaligned.
   function automatic logic misaligned(input logic [MEM_SIZE_BITS-1:0] size, input logic [1:0] off);
      return (size == 2'd3) || (size == MEM_H && off[0]) || (size == MEM_W && off != 2'd0);
   endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: store byte-lane steering / byte enables and load shift with
// sign or zero extension, all combinational.
module lsu_align
   import lsu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [MEM_SIZE_BITS-1:0] size,
   input  logic [1:0]               off,
   input  logic                     uns,
   input  logic [XLEN-1:0]          wdata,
   input  logic [XLEN-1:0]          rdata,
   output logic [XLEN/8-1:0]        be,
   output logic [XLEN-1:0]          st_data,
   output logic [XLEN-1:0]          ld_data
);
   logic [XLEN-1:0] sh;

   always_comb begin
      be      = size == MEM_B ? (XLEN/8)'(4'b0001 << off) :
                size == MEM_H ? (XLEN/8)'(4'b0011 << off) : '1;
      st_data = size == MEM_B ? {4{wdata[7:0]}} :
                size == MEM_H ? {2{wdata[15:0]}} : wdata;
      sh      = rdata >> {off, 3'b000};
      ld_data = size == MEM_B ? {{(XLEN-8){~uns & sh[7]}}, sh[7:0]} :
                size == MEM_H ? {{(XLEN-16){~uns & sh[15]}}, sh[15:0]} : sh;
   end
endmodule

// File: rtl/lsu.sv
// lsu: single-outstanding load/store unit between execute and data memory;
// returns extended load data to writeback and flags misaligned accesses.
module lsu
   import lsu_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int RD_BITS = 5
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_we,
   input  logic [MEM_SIZE_BITS-1:0] req_size,
   input  logic                     req_unsigned,
   input  logic [XLEN-1:0]          req_addr,
   input  logic [XLEN-1:0]          req_wdata,
   input  logic [RD_BITS-1:0]       req_rd,
   input  logic                     flush,
   output logic                     mem_req,
   output logic                     mem_we,
   output logic [XLEN-1:0]          mem_addr,
   output logic [XLEN/8-1:0]        mem_be,
   output logic [XLEN-1:0]          mem_wdata,
   input  logic                     mem_gnt,
   input  logic                     mem_rvalid,
   input  logic [XLEN-1:0]          mem_rdata,
   output logic                     resp_valid,
   output logic [XLEN-1:0]          resp_data,
   output logic [RD_BITS-1:0]       resp_rd,
   output logic                     resp_err
);
   lsu_state_e                 state_q, state_d;
   logic                       discard_q, discard_d;
   logic [XLEN-1:0]            addr_q, wdata_q, rdata_q;
   logic [MEM_SIZE_BITS-1:0]   size_q;
   logic                       we_q, uns_q;
   logic [RD_BITS-1:0]         rd_q;
   logic [XLEN/8-1:0]          be;
   logic [XLEN-1:0]            st_data, ld_data;
   logic                       accept, ld_resp;

   lsu_align #(.XLEN(XLEN)) u_align (
      .size    (size_q),
      .off     (addr_q[1:0]),
      .uns     (uns_q),
      .wdata   (wdata_q),
      .rdata   (mem_rdata),
      .be      (be),
      .st_data (st_data),
      .ld_data (ld_data)
   );

   assign accept = req_valid && req_ready && !flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         discard_q <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         size_q    <= '0;
         we_q      <= 1'b0;
         uns_q     <= 1'b0;
         rd_q      <= '0;
      end else begin
         state_q   <= state_d;
         discard_q <= discard_d;
         if (accept) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            size_q  <= req_size;
            we_q    <= req_we;
            uns_q   <= req_unsigned;
            rd_q    <= req_rd;
         end
         if (state_q == S_WAIT && mem_rvalid) rdata_q <= ld_data;
      end
   end

   // A granted access is committed: a flush then only hides its response.
   always_comb begin
      state_d   = state_q;
      discard_d = discard_q;
      case (state_q)
         S_IDLE: if (accept) state_d = misaligned(req_size, req_addr[1:0]) ? S_ERR : S_REQ;
         S_REQ: begin
            if (mem_gnt) begin
               state_d   = we_q ? (flush ? S_IDLE : S_RESP) : S_WAIT;
               discard_d = flush && !we_q;
            end else if (flush) state_d = S_IDLE;
         end
         S_WAIT: begin
            discard_d = discard_q || flush;
            if (mem_rvalid) begin
               state_d   = (discard_q || flush) ? S_IDLE : S_RESP;
               discard_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign req_ready  = state_q == S_IDLE;
   assign mem_req    = state_q == S_REQ;
   assign mem_we     = mem_req && we_q;
   assign mem_addr   = mem_req ? {addr_q[XLEN-1:2], 2'b00} : '0;
   assign mem_be     = mem_req ? be : '0;
   assign mem_wdata  = mem_we ? st_data : '0;
   assign resp_valid = (state_q == S_RESP || state_q == S_ERR) && !flush;
   assign resp_err   = resp_valid && state_q == S_ERR;
   assign ld_resp    = resp_valid && state_q == S_RESP && !we_q;
   assign resp_data  = ld_resp ? rdata_q : '0;
   assign resp_rd    = ld_resp ? rd_q : '0;
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed and randomized checks of lsu against a byte-addressed
// memory model and spec-level lane/extension arithmetic.
module tb_lsu;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0, flush = 1'b0;
   logic [1:0]  req_size = 2'd0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic [4:0]  req_rd = '0;
   logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        req_ready, mem_req, mem_we, resp_valid, resp_err;
   logic [31:0] mem_addr, mem_wdata, resp_data;
   logic [3:0]  mem_be;
   logic [4:0]  resp_rd;
   int          n_cmp = 0, n_err = 0;
   logic [31:0] mem [logic [29:0]];
   logic [31:0] got;

   lsu dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd), .flush(flush),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata), .resp_valid(resp_valid), .resp_data(resp_data),
      .resp_rd(resp_rd), .resp_err(resp_err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
      req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
      req_addr = a; req_wdata = wd; req_rd = rd;
      tick();
      req_valid = 1'b0;
   endtask

   // Full transaction from IDLE: gd grant-stall cycles, rvalid rl cycles after grant.
   task automatic op(input logic we, input logic [1:0] sz, input logic uns,
                     input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                     input int gd, input int rl, output logic [31:0] res);
      int nb, o;
      logic mis;
      logic [3:0] ebe;
      logic [31:0] ewd, word, exp;
      logic [29:0] wa;
      nb  = 1 << sz;
      o   = int'(a % 4);
      mis = (sz == 2'd3) || (a % nb != 0);
      wa  = a[31:2];
      for (int k = 0; k < 4; k++) begin
         ebe[k] = (k >= o) && (k < o + nb);
         ewd[8*k +: 8] = wd[8*(k % nb) +: 8];
      end
      chk("ready_before", {31'd0, req_ready}, 32'd1);
      issue(we, sz, uns, a, wd, rd);
      if (mis) begin
         chk("mis_mem_req", {31'd0, mem_req}, 32'd0);
         chk("mis_valid", {31'd0, resp_valid}, 32'd1);
         chk("mis_err", {31'd0, resp_err}, 32'd1);
         chk("mis_data", resp_data, 32'd0);
         chk("mis_rd", {27'd0, resp_rd}, 32'd0);
         res = resp_data;
         tick();
         chk("mis_mem_req2", {31'd0, mem_req}, 32'd0);
      end else begin
         for (int i = 0; i <= gd; i++) begin
            chk("req", {31'd0, mem_req}, 32'd1);
            chk("ready_busy", {31'd0, req_ready}, 32'd0);
            chk("addr", mem_addr, {a[31:2], 2'b00});
            chk("be", {28'd0, mem_be}, {28'd0, ebe});
            chk("we", {31'd0, mem_we}, {31'd0, we});
            if (we) chk("wdata", mem_wdata, ewd);
            chk("no_resp_req", {31'd0, resp_valid}, 32'd0);
            if (i == gd) mem_gnt = 1'b1;
            tick();
            mem_gnt = 1'b0;
         end
         if (we) begin
            if (!mem.exists(wa)) mem[wa] = $urandom;
            word = mem[wa];
            for (int k = 0; k < 4; k++) if (ebe[k]) word[8*k +: 8] = ewd[8*k +: 8];
            mem[wa] = word;
            exp = 32'd0;
         end else begin
            if (!mem.exists(wa)) mem[wa] = $urandom;
            word = mem[wa];
            exp = 32'd0;
            for (int k = 0; k < nb; k++) exp[8*k +: 8] = word[8*(o+k) +: 8];
            if (!uns && nb < 4 && exp[8*nb-1])
               for (int k = nb; k < 4; k++) exp[8*k +: 8] = 8'hFF;
            for (int i = 1; i < rl; i++) begin
               chk("wait_req", {31'd0, mem_req}, 32'd0);
               chk("wait_resp", {31'd0, resp_valid}, 32'd0);
               tick();
            end
            mem_rvalid = 1'b1;
            mem_rdata  = word;
            tick();
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
         end
         chk("resp_valid", {31'd0, resp_valid}, 32'd1);
         chk("resp_err", {31'd0, resp_err}, 32'd0);
         chk("resp_data", resp_data, exp);
         chk("resp_rd", {27'd0, resp_rd}, we ? 32'd0 : {27'd0, rd});
         res = resp_data;
         tick();
      end
      chk("resp_pulse", {31'd0, resp_valid}, 32'd0);
      chk("ready_after", {31'd0, req_ready}, 32'd1);
   endtask

   initial begin
      #2;
      chk("rst_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
      chk("rst_outputs", resp_data | mem_addr | mem_wdata | {28'd0, mem_be} | {27'd0, resp_rd}, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      op(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 5'd9, 0, 1, got);
      mem[30'h80] = 32'h80112233;
      op(1'b0, 2'd0, 1'b0, 32'h203, 32'h0, 5'd5, 0, 1, got);
      chk("lb_signed", got, 32'hFFFFFF80);
      op(1'b0, 2'd0, 1'b1, 32'h203, 32'h0, 5'd5, 0, 1, got);
      chk("lbu", got, 32'h00000080);
      mem[30'h4] = 32'h0;
      op(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000ABCD, 5'd3, 0, 1, got);
      chk("sh_word", mem[30'h4], 32'hABCD0000);
      op(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 5'd7, 0, 1, got);
      chk("lhu", got, 32'h0000ABCD);
      op(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 5'd4, 0, 1, got);
      op(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 5'd6, 4, 2, got);
      chk("lw_stalled", got, 32'hDEADBEEF);

      // flush while request is ungranted
      issue(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 5'd8);
      chk("fl_req1", {31'd0, mem_req}, 32'd1);
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("fl_req_drop", {31'd0, mem_req}, 32'd0);
      chk("fl_no_resp", {31'd0, resp_valid}, 32'd0);
      chk("fl_ready", {31'd0, req_ready}, 32'd1);
      tick();
      chk("fl_no_resp2", {31'd0, resp_valid}, 32'd0);

      // flush in WAIT: read drained, no response, new request blocked until rvalid
      issue(1'b0, 2'd2, 1'b0, 32'h44, 32'h0, 5'd8);
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h48; req_rd = 5'd2;
      #1;
      chk("wf_ready0", {31'd0, req_ready}, 32'd0);
      chk("wf_no_resp", {31'd0, resp_valid}, 32'd0);
      tick();
      chk("wf_ready1", {31'd0, req_ready}, 32'd0);
      chk("wf_no_req", {31'd0, mem_req}, 32'd0);
      mem_rvalid = 1'b1;
      mem_rdata = 32'h12345678;
      tick();
      mem_rvalid = 1'b0;
      req_valid = 1'b0;
      chk("wf_no_resp2", {31'd0, resp_valid}, 32'd0);
      chk("wf_ready2", {31'd0, req_ready}, 32'd1);
      mem[30'h12] = 32'hCAFEF00D;
      op(1'b0, 2'd2, 1'b0, 32'h48, 32'h0, 5'd2, 0, 3, got);
      chk("wf_next_load", got, 32'hCAFEF00D);

      // flush in IDLE blocks acceptance
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h300; flush = 1'b1;
      tick();
      req_valid = 1'b0; flush = 1'b0;
      chk("idle_fl_ready", {31'd0, req_ready}, 32'd1);
      chk("idle_fl_req", {31'd0, mem_req}, 32'd0);

      // flush in RESP hides the pulse
      issue(1'b1, 2'd2, 1'b0, 32'h300, 32'h1, 5'd1);
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      flush = 1'b1;
      #1;
      chk("resp_fl", {31'd0, resp_valid}, 32'd0);
      tick();
      flush = 1'b0;
      chk("resp_fl_ready", {31'd0, req_ready}, 32'd1);

      // async reset mid-request
      issue(1'b1, 2'd2, 1'b0, 32'h304, 32'h2, 5'd1);
      chk("ar_req", {31'd0, mem_req}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("ar_req_drop", {31'd0, mem_req}, 32'd0);
      chk("ar_ready", {31'd0, req_ready}, 32'd1);
      tick();
      rst_n = 1'b1;
      tick();

      for (int n = 0; n < 60; n++) begin
         op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            32'($urandom_range(0, 63)), $urandom, 5'($urandom_range(1, 31)),
            $urandom_range(0, 2), $urandom_range(1, 3), got);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit directly downstream of the ALU in the execute path.
- Consumes the ALU result as the effective address, plus rs2 data and memory-op control from decode.
- Runs a single outstanding access on the data-memory request/grant/rvalid interface.
- Returns aligned, sign/zero-extended load data and rd to writeback; raises a misalignment error without touching memory.

Parameters:
- XLEN, 32, data/address width; only 32 is supported, so byte-enable width is XLEN/8 = 4.
- RD_BITS, 5, destination register index width.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  execute stage presents a memory op
- req_ready  out  1  LSU can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  `MEM_B=0, `MEM_H=1, `MEM_W=2; 3 is treated as misaligned
- req_unsigned  in  1  zero-extend load (LBU/LHU)
- req_addr  in  XLEN  effective address (ALU out)
- req_wdata  in  XLEN  store data (rs2)
- req_rd  in  RD_BITS  load destination
- flush  in  1  kill in-flight op (branch mispredict/trap)
- mem_req  out  1  memory request
- mem_we  out  1  write strobe
- mem_addr  out  XLEN  word address, bits [1:0] forced to 0
- mem_be  out  4  byte enables
- mem_wdata  out  XLEN  lane-steered store data
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  XLEN  read word
- resp_valid  out  1  one-cycle completion pulse
- resp_data  out  XLEN  extended load data, 0 for stores/errors
- resp_rd  out  RD_BITS  destination; 0 for stores/errors
- resp_err  out  1  misaligned access

Behaviour:
- Reset (async, rst_n low) values:
  - state=IDLE, req_ready=1, mem_req=0, resp_valid=0, resp_err=0.
  - All data outputs 0; discard flag 0.
- Accept: req_valid && req_ready latches addr, wdata, size, we, unsigned, rd.
- Misalignment is computed at accept:
  - H with addr[0]=1; W with addr[1:0]!=0; size=3.
- FSM states and transitions:
  - IDLE: on accept, go to ERR if misaligned, else REQ.
  - REQ: mem_req=1 with stable addr/be/wdata/we until mem_gnt.
    - gnt && store -> RESP.
    - gnt && load -> WAIT.
  - WAIT: mem_rvalid -> RESP; capture extended rdata. rvalid in the gnt cycle is not legal (memory latency is at least 1).
  - RESP: resp_valid=1 for exactly one cycle, then IDLE.
  - ERR: resp_valid=1, resp_err=1, resp_rd=0, then IDLE. No memory request is issued.
- Byte lanes, with o = addr[1:0]:
  - B: be = 4'b0001<<o; wdata = byte replicated ×4.
  - H: be = 4'b0011<<o; wdata = half replicated ×2.
  - W: be = 4'hF.
- Load extraction:
  - Shift rdata right by 8*o and take the low 8/16/32 bits.
  - Sign-extend unless req_unsigned; W ignores req_unsigned.
- Latency: aligned load with gnt in the first REQ cycle and rvalid one cycle later gives resp_valid 3 cycles after accept. Store gives 2 cycles. Misaligned gives 1 cycle.
- Flush rules:
  - IDLE: ignored; req_ready stays high. A req_valid in the same cycle is not accepted (flush dominates).
  - REQ with no gnt that cycle: drop mem_req next cycle, go to IDLE, no resp.
  - REQ with gnt in the same cycle: the access is committed. Set discard and go to WAIT (load) or IDLE (store, no resp).
  - WAIT: set discard; on rvalid go to IDLE with no resp. The outstanding read must be drained.
  - RESP/ERR: flush suppresses resp_valid in that cycle.
- Reset mid-operation drops mem_req immediately (async). The memory side must also be reset.
- The response does not back-pressure: writeback always accepts resp_valid.

Decomposition:
- defines.sv gains `MEM_B/`MEM_H/`MEM_W, `MEM_SIZE_BITS=2 and the LSU state encoding, next to the existing ALU op codes.
- Sub-module lsu_align (combinational) does store lane steering/byte enables and load shift plus extension. The FSM stays in lsu.

Test Plan:
- Store word addr=0x100, wdata=0xDEADBEEF, gnt at once -> mem_addr=0x100, be=4'hF, mem_wdata=0xDEADBEEF, we=1; resp_valid 2 cycles after accept, resp_rd=0.
- Load byte signed addr=0x203, rdata=0x80112233 one cycle after gnt -> be=4'b1000, resp_data=0xFFFFFF80; with unsigned -> 0x00000080; resp_rd echoes req_rd=5.
- Store half addr=0x12, wdata=0x0000ABCD -> be=4'b1100, mem_wdata=0xABCDABCD; load half unsigned from the same lane with rdata=0xABCD0000 -> 0x0000ABCD.
- Misaligned word addr=0x102 -> no mem_req ever; resp_valid and resp_err next cycle, resp_data=0.
- Grant stalled 4 cycles -> mem_req, addr, be held stable and req_ready=0 throughout. flush on cycle 2 (no gnt) -> mem_req low next cycle, no resp_valid, req_ready=1.
- Load granted, flush in WAIT, rvalid 3 cycles later -> no resp_valid; next load is accepted only after the rvalid cycle and completes normally.
